// File: rtl/fir_requant6_if.sv
// Sample-path bundle for the 6-lane requantizer: lane inputs and block valid in,
// rounded/saturated lanes, saturation flags and statistics out.
interface fir_requant6_if #(
    parameter int IN_W  = 32,
    parameter int OUT_W = 16,
    parameter int CNT_W = 16
);
    logic                    in_valid;
    logic signed [IN_W-1:0]  din0, din1, din2, din3, din4, din5;
    logic                    clr_stats;
    logic                    out_valid;
    logic signed [OUT_W-1:0] dout0, dout1, dout2, dout3, dout4, dout5;
    logic [5:0]              sat_flags;
    logic [CNT_W-1:0]        sat_cnt;
    logic                    sat_sticky;

    modport master (
        output in_valid, din0, din1, din2, din3, din4, din5, clr_stats,
        input  out_valid, dout0, dout1, dout2, dout3, dout4, dout5,
        input  sat_flags, sat_cnt, sat_sticky
    );

    modport slave (
        input  in_valid, din0, din1, din2, din3, din4, din5, clr_stats,
        output out_valid, dout0, dout1, dout2, dout3, dout4, dout5,
        output sat_flags, sat_cnt, sat_sticky
    );
endinterface

// File: rtl/fir_requant6.sv
// Q2.30 -> Q1.15 requantizer for the 6-lane FIR: round-half-up, saturate,
// drop the start-up transient and keep saturation statistics.
module fir_requant6 #(
    parameter int IN_W   = 32,
    parameter int OUT_W  = 16,
    parameter int SHIFT  = 15,
    parameter int WARMUP = 2,
    parameter int CNT_W  = 16
) (
    input  logic           clk,
    input  logic           rst_n,
    fir_requant6_if.slave  io_bus
);
    localparam int WW = (WARMUP < 1) ? 1 : $clog2(WARMUP + 1);
    localparam logic [WW-1:0]        WARM_END = WW'(WARMUP);
    localparam logic signed [IN_W:0] RND      = (IN_W+1)'(2 ** (SHIFT - 1));
    localparam logic signed [IN_W:0] QMAX     = (IN_W+1)'(2 ** (OUT_W - 1) - 1);
    localparam logic signed [IN_W:0] QMIN     = ~QMAX;

    logic signed [IN_W-1:0]  w_din [6];
    logic signed [IN_W:0]    w_q   [6];
    logic signed [IN_W:0]    r_q   [6];
    logic signed [OUT_W-1:0] w_sat [6];
    logic signed [OUT_W-1:0] r_dout[6];
    logic [5:0]              w_flag;
    logic [5:0]              r_flags;
    logic [WW-1:0]           r_warm;
    logic [1:0]              r_vld;
    logic                    w_acc;
    logic [2:0]              w_pop;
    logic [CNT_W:0]          w_sum;
    logic [CNT_W-1:0]        r_cnt;
    logic                    r_sticky;

    assign w_din[0] = io_bus.din0;
    assign w_din[1] = io_bus.din1;
    assign w_din[2] = io_bus.din2;
    assign w_din[3] = io_bus.din3;
    assign w_din[4] = io_bus.din4;
    assign w_din[5] = io_bus.din5;

    // Blocks arriving before the FIR history is full are processed but never marked valid.
    assign w_acc = io_bus.in_valid && (r_warm == WARM_END);

    always_comb begin
        w_flag = '0;
        for (int k = 0; k < 6; k++) begin
            // One guard bit keeps the rounding add from wrapping at the positive extreme.
            w_q[k]   = ($signed({w_din[k][IN_W-1], w_din[k]}) + RND) >>> SHIFT;
            w_sat[k] = r_q[k][OUT_W-1:0];
            if (r_q[k] > QMAX) begin
                w_sat[k]  = QMAX[OUT_W-1:0];
                w_flag[k] = 1'b1;
            end else if (r_q[k] < QMIN) begin
                w_sat[k]  = QMIN[OUT_W-1:0];
                w_flag[k] = 1'b1;
            end
        end
    end

    always_comb begin
        w_pop = '0;
        for (int k = 0; k < 6; k++) begin
            w_pop = w_pop + 3'(r_flags[k]);
        end
        w_sum = {1'b0, r_cnt} + (CNT_W+1)'(w_pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_warm   <= '0;
            r_vld    <= '0;
            r_q      <= '{default: '0};
            r_dout   <= '{default: '0};
            r_flags  <= '0;
            r_cnt    <= '0;
            r_sticky <= 1'b0;
        end else begin
            if (io_bus.in_valid && (r_warm != WARM_END)) begin
                r_warm <= r_warm + WW'(1);
            end
            r_vld <= {r_vld[0], w_acc};
            if (w_acc) begin
                r_q <= w_q;
            end
            // Output lanes and flags hold through gaps.
            if (r_vld[0]) begin
                r_dout  <= w_sat;
                r_flags <= w_flag;
            end
            if (io_bus.clr_stats) begin
                r_cnt    <= '0;
                r_sticky <= 1'b0;
            end else if (r_vld[1]) begin
                r_cnt    <= w_sum[CNT_W] ? '1 : w_sum[CNT_W-1:0];
                r_sticky <= r_sticky | (|r_flags);
            end
        end
    end

    assign io_bus.out_valid  = r_vld[1];
    assign io_bus.dout0      = r_dout[0];
    assign io_bus.dout1      = r_dout[1];
    assign io_bus.dout2      = r_dout[2];
    assign io_bus.dout3      = r_dout[3];
    assign io_bus.dout4      = r_dout[4];
    assign io_bus.dout5      = r_dout[5];
    assign io_bus.sat_flags  = r_flags;
    assign io_bus.sat_cnt    = r_cnt;
    assign io_bus.sat_sticky = r_sticky;
endmodule

// File: tb/tb_fir_requant6.sv
// Bench for fir_requant6: two instances (16-bit and 4-bit statistics counters) share
// stimulus and are checked against a cycle-stamped queue model and a vector table.
module tb_fir_requant6;
    logic clk = 1'b0;
    logic rst_n = 1'b1;
    always #5 clk = ~clk;

    fir_requant6_if #(.IN_W(32), .OUT_W(16), .CNT_W(16)) bus_a ();
    fir_requant6_if #(.IN_W(32), .OUT_W(16), .CNT_W(4))  bus_b ();

    fir_requant6 #(.CNT_W(16)) dut_a (.clk(clk), .rst_n(rst_n), .io_bus(bus_a));
    fir_requant6 #(.CNT_W(4))  dut_b (.clk(clk), .rst_n(rst_n), .io_bus(bus_b));

    assign bus_b.in_valid  = bus_a.in_valid;
    assign bus_b.din0      = bus_a.din0;
    assign bus_b.din1      = bus_a.din1;
    assign bus_b.din2      = bus_a.din2;
    assign bus_b.din3      = bus_a.din3;
    assign bus_b.din4      = bus_a.din4;
    assign bus_b.din5      = bus_a.din5;
    assign bus_b.clr_stats = bus_a.clr_stats;

    logic signed [15:0] a_dout [6];
    assign a_dout[0] = bus_a.dout0;
    assign a_dout[1] = bus_a.dout1;
    assign a_dout[2] = bus_a.dout2;
    assign a_dout[3] = bus_a.dout3;
    assign a_dout[4] = bus_a.dout4;
    assign a_dout[5] = bus_a.dout5;

    typedef struct packed {
        logic [5:0][31:0] lanes;
        logic [5:0][15:0] dout;
        logic [5:0]       flags;
    } vec_t;

    typedef struct packed {
        int               due;
        logic [5:0][15:0] dout;
        logic [5:0]       flags;
    } blk_t;

    int n_pass = 0;
    int n_total = 0;

    blk_t             mq[$];
    int               cyc = 0;
    int               m_warm = 0;
    longint           m_cnt16 = 0;
    longint           m_cnt4 = 0;
    bit               m_sticky = 0;
    logic [5:0][15:0] m_dout = '0;
    logic [5:0]       m_flags = '0;
    bit               m_prev_ov = 0;
    vec_t             tbl [3];

    task automatic chk(input string name, input longint act, input longint exp);
        n_total++;
        if (act == exp) n_pass++;
        else $display("FAIL %s: got %0d expected %0d (t=%0t)", name, act, exp, $time);
    endtask

    // Requantization from the arithmetic definition: floor((x + 2^14) / 2^15), clamped.
    function automatic void rq(input longint d, output longint o, output bit s);
        longint t;
        longint fl;
        t = d + 16384;
        if (t >= 0) fl = t / 32768;
        else        fl = -((-t + 32767) / 32768);
        s = 1'b1;
        if (fl > 32767)       o = 32767;
        else if (fl < -32768) o = -32768;
        else begin
            o = fl;
            s = 1'b0;
        end
    endfunction

    function automatic longint sat_add(input longint a, input longint b, input longint mx);
        return (a + b > mx) ? mx : a + b;
    endfunction

    task automatic step(input bit v, input logic [5:0][31:0] ln, input bit clr);
        blk_t   b;
        bit     ov;
        int     pc;
        longint o;
        bit     s;
        bus_a.in_valid  = v;
        bus_a.din0      = ln[0];
        bus_a.din1      = ln[1];
        bus_a.din2      = ln[2];
        bus_a.din3      = ln[3];
        bus_a.din4      = ln[4];
        bus_a.din5      = ln[5];
        bus_a.clr_stats = clr;
        @(posedge clk);
        #1;
        if (clr) begin
            m_cnt16 = 0;
            m_cnt4 = 0;
            m_sticky = 0;
        end else if (m_prev_ov) begin
            pc = $countones(m_flags);
            m_cnt16 = sat_add(m_cnt16, pc, 65535);
            m_cnt4 = sat_add(m_cnt4, pc, 15);
            if (pc != 0) m_sticky = 1;
        end
        if (v) begin
            if (m_warm < 2) m_warm++;
            else begin
                b.due = cyc + 1;
                for (int k = 0; k < 6; k++) begin
                    rq(longint'($signed(ln[k])), o, s);
                    b.dout[k] = 16'(o);
                    b.flags[k] = s;
                end
                mq.push_back(b);
            end
        end
        ov = 0;
        if (mq.size() > 0 && mq[0].due == cyc) begin
            b = mq.pop_front();
            m_dout = b.dout;
            m_flags = b.flags;
            ov = 1;
        end
        chk("out_valid", longint'(bus_a.out_valid), longint'(ov));
        chk("out_valid_b", longint'(bus_b.out_valid), longint'(ov));
        for (int k = 0; k < 6; k++)
            chk($sformatf("dout%0d", k), longint'(a_dout[k]), longint'($signed(m_dout[k])));
        chk("sat_flags", longint'(bus_a.sat_flags), longint'(m_flags));
        chk("sat_cnt16", longint'(bus_a.sat_cnt), m_cnt16);
        chk("sat_cnt4", longint'(bus_b.sat_cnt), m_cnt4);
        chk("sat_sticky", longint'(bus_a.sat_sticky), longint'(m_sticky));
        m_prev_ov = ov;
        cyc++;
    endtask

    task automatic do_reset(input int hold);
        rst_n = 1'b0;
        #1;
        chk("rst_out_valid", longint'(bus_a.out_valid | bus_b.out_valid), 0);
        for (int k = 0; k < 6; k++) chk($sformatf("rst_dout%0d", k), longint'(a_dout[k]), 0);
        chk("rst_flags", longint'(bus_a.sat_flags), 0);
        chk("rst_cnt", longint'(bus_a.sat_cnt) + longint'(bus_b.sat_cnt), 0);
        chk("rst_sticky", longint'(bus_a.sat_sticky), 0);
        mq.delete();
        m_warm = 0;
        m_cnt16 = 0;
        m_cnt4 = 0;
        m_sticky = 0;
        m_dout = '0;
        m_flags = '0;
        m_prev_ov = 0;
        bus_a.in_valid = 1'b0;
        bus_a.clr_stats = 1'b0;
        repeat (hold) @(posedge clk);
        @(negedge clk);
        rst_n = 1'b1;
    endtask

    task automatic set_vec(input int i, input int l0, input int l1, input int l2,
                           input int l3, input int l4, input int l5,
                           input int d0, input int d1, input int d2,
                           input int d3, input int d4, input int d5, input logic [5:0] f);
        tbl[i].lanes = {32'(l5), 32'(l4), 32'(l3), 32'(l2), 32'(l1), 32'(l0)};
        tbl[i].dout  = {16'(d5), 16'(d4), 16'(d3), 16'(d2), 16'(d1), 16'(d0)};
        tbl[i].flags = f;
    endtask

    function automatic logic [5:0][31:0] all_lanes(input int x);
        logic [5:0][31:0] r;
        for (int k = 0; k < 6; k++) r[k] = 32'(x);
        return r;
    endfunction

    function automatic logic [5:0][31:0] rnd_lanes();
        logic [5:0][31:0] r;
        for (int k = 0; k < 6; k++) begin
            case ($urandom_range(0, 3))
                0:       r[k] = 32'($urandom);
                1:       r[k] = 32'(1073725440 + int'($urandom_range(0, 64)) - 32);
                2:       r[k] = 32'(-1073758208 + int'($urandom_range(0, 64)) - 32);
                default: r[k] = 32'(int'($urandom_range(0, 200000)) - 100000);
            endcase
        end
        return r;
    endfunction

    initial begin
        logic [5:0][31:0] z;
        logic [6:0]       seq;
        int               n_ov;
        longint           exp_cum;
        int               gap_v [5];
        z = '0;
        bus_a.in_valid = 1'b0;
        bus_a.clr_stats = 1'b0;
        bus_a.din0 = '0; bus_a.din1 = '0; bus_a.din2 = '0;
        bus_a.din3 = '0; bus_a.din4 = '0; bus_a.din5 = '0;

        set_vec(0, 16384, 16383, -16384, -16385, 49152, -49152,
                1, 0, 0, -1, 2, -1, 6'b000000);
        set_vec(1, 1073725439, 1073725440, 32'h7FFF_FFFF, 32'h8000_0000, -1073741824, -1073758209,
                32767, 32767, 32767, -32768, -32768, -32768, 6'b101110);
        set_vec(2, 0, -1, 32767, -32769, 1073741823, -1073741825,
                0, 0, 1, -1, 32767, -32768, 6'b010000);

        #3;
        do_reset(2);

        // Warm-up: four blocks of 32768, only the last two emerge.
        n_ov = 0;
        for (int i = 0; i < 6; i++) begin
            step(i < 4, all_lanes(32768), 1'b0);
            n_ov += int'(bus_a.out_valid);
        end
        chk("warmup_ov_count", n_ov, 2);
        chk("warmup_dout0", longint'(a_dout[0]), 1);
        chk("warmup_cnt", longint'(bus_a.sat_cnt), 0);

        // Vector table: value check one cycle after acceptance, stats one cycle later.
        step(1'b0, z, 1'b1);
        exp_cum = 0;
        for (int i = 0; i < 3; i++) begin
            step(1'b1, tbl[i].lanes, 1'b0);
            step(1'b0, z, 1'b0);
            for (int k = 0; k < 6; k++)
                chk($sformatf("tbl%0d_dout%0d", i, k), longint'(a_dout[k]),
                    longint'($signed(tbl[i].dout[k])));
            chk($sformatf("tbl%0d_flags", i), longint'(bus_a.sat_flags), longint'(tbl[i].flags));
            step(1'b0, z, 1'b0);
            exp_cum += $countones(tbl[i].flags);
            chk($sformatf("tbl%0d_cnt", i), longint'(bus_a.sat_cnt), exp_cum);
            chk($sformatf("tbl%0d_sticky", i), longint'(bus_a.sat_sticky), longint'(exp_cum != 0));
        end

        // Gapped valid 1,0,0,1,1 comes out delayed by one check step.
        gap_v = '{1, 0, 0, 1, 1};
        seq = '0;
        for (int i = 0; i < 7; i++) begin
            step((i < 5) ? bit'(gap_v[i]) : 1'b0, all_lanes(100000 * (i + 1)), 1'b0);
            seq[i] = bus_a.out_valid;
        end
        chk("gap_ov_seq", longint'(seq), longint'(7'b0110010));

        // Narrow counter: 6, 12, then stuck at 15.
        step(1'b0, z, 1'b1);
        for (int i = 0; i < 6; i++) begin
            step(i < 3, all_lanes(32'h7FFF_FFFF), 1'b0);
            if (i == 2) chk("cnt4_first", longint'(bus_b.sat_cnt), 6);
            if (i == 3) chk("cnt4_second", longint'(bus_b.sat_cnt), 12);
            if (i >= 4) chk("cnt4_hold", longint'(bus_b.sat_cnt), 15);
        end

        // Clear coinciding with a saturating out_valid cycle wins.
        step(1'b0, z, 1'b1);
        step(1'b1, all_lanes(32'h8000_0000), 1'b0);
        step(1'b0, z, 1'b0);
        chk("clr_pre_ov", longint'(bus_a.out_valid), 1);
        step(1'b0, z, 1'b1);
        chk("clr_cnt", longint'(bus_a.sat_cnt) + longint'(bus_b.sat_cnt), 0);
        chk("clr_sticky", longint'(bus_a.sat_sticky), 0);
        step(1'b0, z, 1'b0);

        // Reset with blocks in flight, then warm-up must restart.
        step(1'b1, rnd_lanes(), 1'b0);
        step(1'b1, rnd_lanes(), 1'b0);
        do_reset(1);
        n_ov = 0;
        for (int i = 0; i < 6; i++) begin
            step(i < 4, rnd_lanes(), 1'b0);
            n_ov += int'(bus_a.out_valid);
        end
        chk("rst_mid_ov_count", n_ov, 2);

        for (int i = 0; i < 400; i++)
            step($urandom_range(0, 9) < 7, rnd_lanes(), $urandom_range(0, 19) == 0);
        for (int i = 0; i < 3; i++) step(1'b0, z, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
